sequenciador_instrucoes: RTL and testbench
==========================================

Name: sequenciador_instrucoes

Overview:
- Multicycle control FSM for the 8-register, 16-bit bus processor.
- Latches a 9-bit instruction (IIIXXXYYY) from DIN[8:0] when Run is high.
- Sequences steps T0..T3 and drives every bus-driver and register-load strobe: Rout, Rin, Ain, Gin, Gout, AddSub, DINout, IRin.
- Pulses Done at instruction end, then returns to T0.
- Replaces the separate step counter and control decoder as a single registered block.

Parameters:
- N_REGS, 8: width of the one-hot Rin/Rout vectors. Bit N_REGS-1 selects R0; bit 0 selects R7.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  reset, asynchronous, active-low.
- Run  in  1  start request; sampled only in T0.
- Instr  in  9  DIN[8:0]: opcode[8:6], X[5:3], Y[2:0].
- IRin  out  1  load strobe for the datapath IR.
- Rin  out  N_REGS  one-hot register write enable.
- Rout  out  N_REGS  one-hot register bus-drive select.
- Ain  out  1  load A from bus.
- Gin  out  1  load G from ALU.
- Gout  out  1  G drives bus.
- AddSub  out  1  ALU operation: 0 = add, 1 = sub.
- DINout  out  1  DIN drives bus.
- Done  out  1  one-cycle end-of-instruction pulse.
- Tstep  out  2  current step: 00 = T0 … 11 = T3.
- InstrCount  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (Resetn = 0, asynchronous):
  - state = T0, internal IR = 0, InstrCount = 0.
  - All strobes are decoded from state, so every output is 0 while reset is held and in T0 with Run = 0.
- Opcodes:
  - 000 mv Rx,Ry
  - 001 mvi Rx,#D
  - 010 add Rx,Ry
  - 011 sub Rx,Ry
  - 100–111 illegal.
- T0:
  - Run = 1: assert DINout and IRin; latch Instr into internal IR on the clock edge; next state T1.
  - Run = 0: stay in T0 with all outputs 0.
- T1:
  - mv: Rout = onehot(Y), Rin = onehot(X), Done = 1; next T0.
  - mvi: DINout = 1, Rin = onehot(X), Done = 1; next T0. The immediate must already be on DIN during T1.
  - add/sub: Rout = onehot(X), Ain = 1; next T2.
  - illegal: Done = 1 only, with no Rin/Ain/Gin; next T0.
- T2 (add/sub): Rout = onehot(Y), Gin = 1, AddSub = (opcode == 011); next T3.
- T3 (add/sub): Gout = 1, Rin = onehot(X), Done = 1; next T0.
- Latency:
  - mv, mvi and illegal: 2 cycles from Run being sampled.
  - add and sub: 4 cycles.
- Done is high for exactly one cycle. Back-to-back execution: if Run is still high at the following T0, the next fetch starts immediately with no bubble.
- Run and Instr are ignored outside T0. The internal IR is stable from T1 through T3.
- Outputs are combinational from (state, IR); Tstep is the registered state.
- Invariants:
  - At most one bus driver per cycle: popcount(Rout) + Gout + DINout ≤ 1.
  - Rin popcount ≤ 1.
- X == Y, e.g. add R3,R3, is legal; the controller applies no special handling.
- InstrCount increments by 1 on each cycle where Done = 1, including illegal opcodes. It wraps from 2^CNT_W−1 to 0.
- Reset asserted mid-instruction:
  - Immediate return to T0; no Rin/Gin pulse is produced after reset asserts.
  - After Resetn rises, the first fetch happens on the first edge with Run = 1.

Decomposition:
- Package proc_pkg holds:
  - Opcode constants: OP_MV, OP_MVI, OP_ADD, OP_SUB.
  - Step encoding: T0 = 2'b00, T1 = 2'b01, T2 = 2'b10, T3 = 2'b11.
  - Field slice positions for opcode, X and Y.
- One sub-module, decodificador_3x8: 3-bit index to N_REGS-bit one-hot with MSB = R0. It is instantiated twice, for X and for Y.

Test Plan:
- Reset held, Run toggled → all outputs 0, Tstep = 00, InstrCount = 0.
  - Release reset, Run = 1, Instr = 9'b001_000_000 (mvi R0) → T0: IRin = 1, DINout = 1. Next cycle: DINout = 1, Rin = 8'h80, Done = 1.
- mv R2,R1 (9'b000_010_001) → T1: Rout = 8'h40, Rin = 8'h20, Done = 1; InstrCount increments by 1.
- sub R0,R1 (9'b011_000_001):
  - T1: Rout = 8'h80, Ain = 1.
  - T2: Rout = 8'h40, Gin = 1, AddSub = 1.
  - T3: Gout = 1, Rin = 8'h80, Done = 1.
  - Same sequence with add (9'b010_000_001) → AddSub = 0 in T2.
- Run held high with three instructions (mvi, add, mv) → no idle cycles between them. Done pulses occur at cycles 2, 6 and 8, and InstrCount = 3.
- Illegal 9'b111_xxx_xxx → Done = 1 in T1 with Rin = 0 and Ain = Gin = 0.
  - Resetn pulsed low during T2 of an add → outputs go to 0 immediately, Tstep = 00, no Rin pulse follows.
- Preload InstrCount to 16'hFFFF via 65535 mv instructions (or force) → the next Done wraps it to 0.
  - The one-bus-driver assertion holds throughout all scenarios.

Source files
------------

// File: rtl/sequenciador_instrucoes_pkg.sv
// rtl/sequenciador_instrucoes_pkg.sv - opcodes, step encoding and instruction field positions
package proc_pkg;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'b00,
        T1 = 2'b01,
        T2 = 2'b10,
        T3 = 2'b11
    } step_t;

    // Instruction word layout: IIIXXXYYY
    localparam int OP_HI = 8;
    localparam int OP_LO = 6;
    localparam int X_HI  = 5;
    localparam int X_LO  = 3;
    localparam int Y_HI  = 2;
    localparam int Y_LO  = 0;

    function automatic logic [2:0] opcode_of(input logic [8:0] ir);
        return ir[OP_HI:OP_LO];
    endfunction

endpackage

// File: rtl/sequenciador_instrucoes_if.sv
// rtl/sequenciador_instrucoes_if.sv - fetch request and datapath control strobes
interface sequenciador_instrucoes_if #(
    parameter int N_REGS = 8,
    parameter int CNT_W  = 16
);
    logic              Run;
    logic [8:0]        Instr;
    logic              IRin;
    logic [N_REGS-1:0] Rin;
    logic [N_REGS-1:0] Rout;
    logic              Ain;
    logic              Gin;
    logic              Gout;
    logic              AddSub;
    logic              DINout;
    logic              Done;
    logic [1:0]        Tstep;
    logic [CNT_W-1:0]  InstrCount;

    modport master (
        output Run, Instr,
        input  IRin, Rin, Rout, Ain, Gin, Gout, AddSub, DINout, Done, Tstep, InstrCount
    );

    modport slave (
        input  Run, Instr,
        output IRin, Rin, Rout, Ain, Gin, Gout, AddSub, DINout, Done, Tstep, InstrCount
    );
endinterface

// File: rtl/sequenciador_instrucoes_decodificador_3x8.sv
// rtl/sequenciador_instrucoes_decodificador_3x8.sv - register index to one-hot, MSB selects R0
module decodificador_3x8 #(
    parameter int N_REGS = 8
) (
    input  logic [2:0]        idx,
    output logic [N_REGS-1:0] onehot
);
    always_comb begin
        onehot = '0;
        for (int i = 0; i < N_REGS; i++) begin
            onehot[N_REGS-1-i] = (32'(idx) == i);
        end
    end
endmodule

// File: rtl/sequenciador_instrucoes.sv
// rtl/sequenciador_instrucoes.sv - multicycle fetch/execute controller for the 8-register processor
module sequenciador_instrucoes
    import proc_pkg::*;
#(
    parameter int N_REGS = 8,
    parameter int CNT_W  = 16
) (
    input logic                 Clock,
    input logic                 Resetn,
    sequenciador_instrucoes_if.slave bus
);
    step_t             state;
    logic [8:0]        ir;
    logic [CNT_W-1:0]  count;
    logic [2:0]        op;
    logic [N_REGS-1:0] oh_x;
    logic [N_REGS-1:0] oh_y;

    logic              irin, ain, gin, gout, addsub, dinout, done;
    logic [N_REGS-1:0] rin, rout;

    assign op = opcode_of(ir);

    decodificador_3x8 #(.N_REGS(N_REGS)) u_dec_x (.idx(ir[X_HI:X_LO]), .onehot(oh_x));
    decodificador_3x8 #(.N_REGS(N_REGS)) u_dec_y (.idx(ir[Y_HI:Y_LO]), .onehot(oh_y));

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= T0;
            ir    <= '0;
            count <= '0;
        end else begin
            case (state)
                T0: if (bus.Run) begin
                    ir    <= bus.Instr;
                    state <= T1;
                end
                T1: state <= (op == OP_ADD || op == OP_SUB) ? T2 : T0;
                T2: state <= T3;
                T3: state <= T0;
                default: state <= T0;
            endcase
            if (done) count <= count + CNT_W'(1);
        end
    end

    // Fetch strobes are gated by Resetn so nothing drives the bus while reset is held.
    always_comb begin
        irin   = 1'b0;
        ain    = 1'b0;
        gin    = 1'b0;
        gout   = 1'b0;
        addsub = 1'b0;
        dinout = 1'b0;
        done   = 1'b0;
        rin    = '0;
        rout   = '0;
        case (state)
            T0: if (Resetn && bus.Run) begin
                irin   = 1'b1;
                dinout = 1'b1;
            end
            T1: case (op)
                OP_MV: begin
                    rout = oh_y;
                    rin  = oh_x;
                    done = 1'b1;
                end
                OP_MVI: begin
                    dinout = 1'b1;
                    rin    = oh_x;
                    done   = 1'b1;
                end
                OP_ADD, OP_SUB: begin
                    rout = oh_x;
                    ain  = 1'b1;
                end
                default: done = 1'b1;
            endcase
            T2: begin
                rout   = oh_y;
                gin    = 1'b1;
                addsub = (op == OP_SUB);
            end
            T3: begin
                gout = 1'b1;
                rin  = oh_x;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.IRin       = irin;
    assign bus.Rin        = rin;
    assign bus.Rout       = rout;
    assign bus.Ain        = ain;
    assign bus.Gin        = gin;
    assign bus.Gout       = gout;
    assign bus.AddSub     = addsub;
    assign bus.DINout     = dinout;
    assign bus.Done       = done;
    assign bus.Tstep      = state;
    assign bus.InstrCount = count;
endmodule

// File: tb/tb_sequenciador_instrucoes.sv
// tb/tb_sequenciador_instrucoes.sv - directed bench with a per-cycle reference model of the controller
module tb_sequenciador_instrucoes;
    localparam int CNT_W = 6;

    typedef struct packed {
        logic       irin;
        logic [7:0] rin;
        logic [7:0] rout;
        logic       ain;
        logic       gin;
        logic       gout;
        logic       addsub;
        logic       dinout;
        logic       done;
        logic [1:0] tstep;
    } rec_t;

    logic clk = 1'b0;
    logic Resetn;
    int   vectors = 0;
    int   miscompares = 0;
    rec_t q[$];
    int   mcount = 0;

    sequenciador_instrucoes_if #(.N_REGS(8), .CNT_W(CNT_W)) bus ();

    sequenciador_instrucoes #(.N_REGS(8), .CNT_W(CNT_W)) dut (
        .Clock  (clk),
        .Resetn (Resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] oh(input int r);
        return 8'h80 >> r;
    endfunction

    function automatic rec_t actual();
        return {bus.IRin, bus.Rin, bus.Rout, bus.Ain, bus.Gin, bus.Gout,
                bus.AddSub, bus.DINout, bus.Done, bus.Tstep};
    endfunction

    // Every cycle the instruction occupies, listed in order, starting with the fetch.
    task automatic expand(input logic [8:0] ins);
        rec_t e;
        int   opc = int'(ins[8:6]);
        int   x = int'(ins[5:3]);
        int   y = int'(ins[2:0]);
        e = '0; e.irin = 1; e.dinout = 1; e.tstep = 2'd0; q.push_back(e);
        e = '0; e.tstep = 2'd1;
        if (opc == 0) begin
            e.rout = oh(y); e.rin = oh(x); e.done = 1; q.push_back(e);
        end else if (opc == 1) begin
            e.dinout = 1; e.rin = oh(x); e.done = 1; q.push_back(e);
        end else if (opc == 2 || opc == 3) begin
            e.rout = oh(x); e.ain = 1; q.push_back(e);
            e = '0; e.tstep = 2'd2; e.rout = oh(y); e.gin = 1; e.addsub = (opc == 3); q.push_back(e);
            e = '0; e.tstep = 2'd3; e.gout = 1; e.rin = oh(x); e.done = 1; q.push_back(e);
        end else begin
            e.done = 1; q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        rec_t e;
        rec_t a;
        e = '0;
        if (!Resetn) begin
            q.delete();
            mcount = 0;
        end else begin
            if (q.size() == 0 && bus.Run) expand(bus.Instr);
            if (q.size() != 0) e = q.pop_front();
        end
        a = actual();
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL model_outputs t=%0t: got %h expected %h", $time, a, e);
        end
        vectors++;
        if (int'(bus.InstrCount) != mcount) begin
            miscompares++;
            $display("FAIL model_count t=%0t: got %0d expected %0d", $time, bus.InstrCount, mcount);
        end
        vectors++;
        if ($countones(bus.Rout) + int'(bus.Gout) + int'(bus.DINout) > 1 || $countones(bus.Rin) > 1) begin
            miscompares++;
            $display("FAIL bus_drivers t=%0t: Rout=%h Gout=%b DINout=%b Rin=%h", $time, bus.Rout, bus.Gout, bus.DINout, bus.Rin);
        end
        if (e.done) mcount = (mcount + 1) % (1 << CNT_W);
    end

    task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        @(negedge clk);
        next();
        Resetn = 1'b1;
    endtask

    initial begin
        logic [8:0] chain_ins [3];
        int         chain_lat [3];
        int         done_at [$];
        int         c;
        logic [8:0] ab [2];

        Resetn = 1'b0;
        bus.Run = 1'b0;
        bus.Instr = 9'b001_000_000;
        for (int i = 0; i < 4; i++) begin
            bus.Run = i[0];
            @(negedge clk);
            pin("reset_outputs", 32'(actual()), 32'h0);
            pin("reset_count", 32'(bus.InstrCount), 32'h0);
            next();
        end

        // mvi R0
        Resetn = 1'b1;
        bus.Run = 1'b1;
        bus.Instr = 9'b001_000_000;
        @(negedge clk);
        pin("mvi_t0_irin", 32'(bus.IRin), 1);
        pin("mvi_t0_dinout", 32'(bus.DINout), 1);
        next();
        bus.Run = 1'b0;
        bus.Instr = 9'h1FF;
        @(negedge clk);
        pin("mvi_t1_dinout", 32'(bus.DINout), 1);
        pin("mvi_t1_rin", 32'(bus.Rin), 32'h80);
        pin("mvi_t1_done", 32'(bus.Done), 1);
        next();

        // mv R2,R1
        bus.Run = 1'b1;
        bus.Instr = 9'b000_010_001;
        @(negedge clk);
        next();
        bus.Run = 1'b0;
        @(negedge clk);
        pin("mv_t1_rout", 32'(bus.Rout), 32'h40);
        pin("mv_t1_rin", 32'(bus.Rin), 32'h20);
        pin("mv_t1_done", 32'(bus.Done), 1);
        pin("mv_count_before", 32'(bus.InstrCount), 1);
        next();
        pin("mv_count_after", 32'(bus.InstrCount), 2);

        // sub R0,R1 then add R0,R1
        ab[0] = 9'b011_000_001;
        ab[1] = 9'b010_000_001;
        for (int k = 0; k < 2; k++) begin
            bus.Run = 1'b1;
            bus.Instr = ab[k];
            @(negedge clk);
            next();
            bus.Run = 1'b0;
            @(negedge clk);
            pin("alu_t1_rout", 32'(bus.Rout), 32'h80);
            pin("alu_t1_ain", 32'(bus.Ain), 1);
            next();
            @(negedge clk);
            pin("alu_t2_rout", 32'(bus.Rout), 32'h40);
            pin("alu_t2_gin", 32'(bus.Gin), 1);
            pin("alu_t2_addsub", 32'(bus.AddSub), (k == 0) ? 1 : 0);
            next();
            @(negedge clk);
            pin("alu_t3_gout", 32'(bus.Gout), 1);
            pin("alu_t3_rin", 32'(bus.Rin), 32'h80);
            pin("alu_t3_done", 32'(bus.Done), 1);
            next();
        end

        // illegal opcode
        bus.Run = 1'b1;
        bus.Instr = 9'b111_101_010;
        @(negedge clk);
        next();
        bus.Run = 1'b0;
        @(negedge clk);
        pin("ill_done", 32'(bus.Done), 1);
        pin("ill_rin", 32'(bus.Rin), 0);
        pin("ill_ain_gin", 32'({bus.Ain, bus.Gin}), 0);
        next();
        pin("ill_back_t0", 32'(bus.Tstep), 0);

        // back-to-back mvi R5, add R3,R3, mv R1,R6 with Run held
        do_reset();
        chain_ins[0] = 9'b001_101_000; chain_lat[0] = 2;
        chain_ins[1] = 9'b010_011_011; chain_lat[1] = 4;
        chain_ins[2] = 9'b000_001_110; chain_lat[2] = 2;
        bus.Run = 1'b1;
        c = 0;
        for (int k = 0; k < 3; k++) begin
            bus.Instr = chain_ins[k];
            for (int j = 0; j < chain_lat[k]; j++) begin
                c++;
                @(negedge clk);
                if (bus.Done) done_at.push_back(c);
                next();
            end
        end
        bus.Run = 1'b0;
        pin("chain_done_count", 32'(done_at.size()), 3);
        if (done_at.size() == 3) begin
            pin("chain_done0", 32'(done_at[0]), 2);
            pin("chain_done1", 32'(done_at[1]), 6);
            pin("chain_done2", 32'(done_at[2]), 8);
        end
        pin("chain_count", 32'(bus.InstrCount), 3);

        // reset during T2 of add R1,R2
        bus.Run = 1'b1;
        bus.Instr = 9'b010_001_010;
        @(negedge clk);
        next();
        bus.Run = 1'b0;
        @(negedge clk);
        next();
        #2;
        Resetn = 1'b0;
        #1;
        pin("midrst_tstep", 32'(bus.Tstep), 0);
        pin("midrst_outputs", 32'(actual()), 0);
        @(negedge clk);
        next();
        Resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pin("midrst_no_rin", 32'({bus.Rin, bus.Gin}), 0);
            pin("midrst_idle", 32'(bus.Tstep), 0);
            next();
        end

        // counter wrap with mv R0,R7 back-to-back
        do_reset();
        bus.Run = 1'b1;
        bus.Instr = 9'b000_000_111;
        for (int n = 0; n < (1 << CNT_W) - 1; n++) begin
            next();
            next();
        end
        pin("wrap_full", 32'(bus.InstrCount), (1 << CNT_W) - 1);
        next();
        bus.Run = 1'b0;
        next();
        pin("wrap_zero", 32'(bus.InstrCount), 0);
        next();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
        $fatal(1, "watchdog");
    end
endmodule
